// File: rtl/ro_measure_ctrl.sv
// Ring-oscillator measurement sequencer: enable, optional settle, windowed edge count, latch, serial readout.
// Optional settle phase is built when RO_CTRL_SETTLE_EN is defined.
module ro_measure_ctrl #(
  parameter int CNT_W         = 16,
  parameter int WIN_LOG2      = 10,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             ro_div,
  input  logic             shift,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] count,
  output logic             sdo
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COUNT   = 2'd2;
  localparam logic [1:0] ST_CAPTURE = 2'd3;

`ifdef RO_CTRL_SETTLE_EN
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TMR_W = (SET_W > WIN_LOG2) ? SET_W : WIN_LOG2;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
`else
  // SETTLE_CYCLES has no effect in this build; the timer only spans the window.
  localparam int TMR_W = WIN_LOG2 + 0 * SETTLE_CYCLES;
`endif
  localparam logic [TMR_W-1:0] WIN_LAST = TMR_W'((64'd1 << WIN_LOG2) - 64'd1);

  logic [1:0]       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_win_q, ovf_win_d;
  logic             capture;

  logic             ro_s1_q, ro_s2_q, ro_hist_q;
  logic             edge_p;

  logic             done_q;
  logic             ovf_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] sr_q;

  assign edge_p = ro_s2_q & ~ro_hist_q;

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    cnt_d     = cnt_q;
    ovf_win_d = ovf_win_q;
    capture   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tmr_d     = '0;
          cnt_d     = '0;
          ovf_win_d = 1'b0;
`ifdef RO_CTRL_SETTLE_EN
          state_d   = ST_SETTLE;
`else
          state_d   = ST_COUNT;
`endif
        end
      end
`ifdef RO_CTRL_SETTLE_EN
      ST_SETTLE: begin
        if (tmr_q == SETTLE_LAST) begin
          state_d = ST_COUNT;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
`endif
      ST_COUNT: begin
        // An edge arriving at all-ones is lost, so it marks the window as overflowed.
        if (edge_p) begin
          if (&cnt_q) ovf_win_d = 1'b1;
          else        cnt_d     = cnt_q + 1'b1;
        end
        if (tmr_q == WIN_LAST) state_d = ST_CAPTURE;
        else                   tmr_d   = tmr_q + 1'b1;
      end
      ST_CAPTURE: begin
        capture = 1'b1;
        if (continuous) begin
          state_d   = ST_COUNT;
          tmr_d     = '0;
          cnt_d     = '0;
          ovf_win_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      cnt_q     <= '0;
      ovf_win_q <= 1'b0;
      ro_s1_q   <= 1'b0;
      ro_s2_q   <= 1'b0;
      ro_hist_q <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      count_q   <= '0;
      sr_q      <= '0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      cnt_q     <= cnt_d;
      ovf_win_q <= ovf_win_d;
      ro_s1_q   <= ro_div;
      ro_s2_q   <= ro_s1_q;
      ro_hist_q <= ro_s2_q;
      done_q    <= capture;
      // A load in the capture cycle takes priority over a coincident shift.
      if (capture) begin
        count_q <= cnt_q;
        ovf_q   <= ovf_win_q;
        sr_q    <= cnt_q;
      end else if (shift) begin
        sr_q <= sr_q << 1;
      end
    end
  end

  assign ro_en    = (state_q != ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign count    = count_q;
  assign sdo      = sr_q[CNT_W-1];

endmodule

// File: tb/tb_ro_measure_ctrl.sv
// Bench for ro_measure_ctrl: directed measurements, scoreboard of expected results checked on done.
module tb_ro_measure_ctrl;

`ifdef RO_CTRL_SETTLE_EN
  localparam int SETTLE_ADD = 16;
`else
  localparam int SETTLE_ADD = 0;
`endif
  localparam int PERIOD = 65;                // 2^6 window + capture cycle
  localparam int LAT    = PERIOD + SETTLE_ADD;
  localparam int S_LAT  = 257 + SETTLE_ADD;  // 2^8 window + capture cycle

  logic        clk;
  logic        rst_n;
  logic        start, continuous, ro_div, shift;
  logic        ro_en, busy, done, overflow, sdo;
  logic [15:0] count;
  logic        start_s, cont_s, shift_s;
  logic        ro_en_s, busy_s, done_s, overflow_s, sdo_s;
  logic [3:0]  count_s;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ro_half = 0;
  int burst_req = 0;
  int burst_done = 0;

  logic [16:0] exp_q[$];
  int          exp_t_q[$];
  logic [16:0] exp_s_q[$];
  int          exp_s_t_q[$];

  ro_measure_ctrl #(.CNT_W(16), .WIN_LOG2(6), .SETTLE_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .ro_div(ro_div), .shift(shift), .ro_en(ro_en), .busy(busy), .done(done),
    .overflow(overflow), .count(count), .sdo(sdo)
  );

  ro_measure_ctrl #(.CNT_W(4), .WIN_LOG2(8), .SETTLE_CYCLES(16)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .continuous(cont_s),
    .ro_div(ro_div), .shift(shift_s), .ro_en(ro_en_s), .busy(busy_s), .done(done_s),
    .overflow(overflow_s), .count(count_s), .sdo(sdo_s)
  );

  // clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // oscillator model: burst pulses (2 high / 2 low) take priority over free-running toggling
  initial begin
    ro_div = 1'b0;
    forever begin
      if (burst_done != burst_req) begin
        ro_div = 1'b1;
        repeat (2) @(negedge clk);
        ro_div = 1'b0;
        repeat (2) @(negedge clk);
        burst_done++;
      end else if (ro_half != 0) begin
        ro_div = ~ro_div;
        repeat (ro_half) @(negedge clk);
      end else begin
        ro_div = 1'b0;
        @(negedge clk);
      end
    end
  end

  // scoreboard monitors
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        logic [16:0] e;
        int          t;
        e = exp_q.pop_front();
        t = exp_t_q.pop_front();
        check("done_cycle", 32'(cyc), 32'(t));
        check("count", 32'(count), 32'(e[15:0]));
        check("overflow", 32'(overflow), 32'(e[16]));
      end
    end
  end

  always @(negedge clk) begin
    if (done_s === 1'b1) begin
      if (exp_s_q.size() == 0) begin
        check("unexpected_done_s", 32'(done_s), 32'd0);
      end else begin
        logic [16:0] e;
        int          t;
        e = exp_s_q.pop_front();
        t = exp_s_t_q.pop_front();
        check("done_cycle_s", 32'(cyc), 32'(t));
        check("count_s", 32'(count_s), 32'(e[3:0]));
        check("overflow_s", 32'(overflow_s), 32'(e[16]));
      end
    end
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // Pulses start on one DUT and queues nexp results spaced gap cycles apart.
  task automatic fire_start(input bit sel, input int nexp, input logic [16:0] e, input int gap,
                            output int t0);
    t0 = cyc + 1;
    for (int k = 0; k < nexp; k++) begin
      if (sel) begin
        exp_s_q.push_back(e);
        exp_s_t_q.push_back(t0 + S_LAT + k * gap);
      end else begin
        exp_q.push_back(e);
        exp_t_q.push_back(t0 + LAT + k * gap);
      end
    end
    if (sel) start_s = 1'b1;
    else     start   = 1'b1;
    step();
    start   = 1'b0;
    start_s = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_s_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(exp_q.size() + exp_s_q.size()), 32'd0);
  endtask

  initial begin
    int          t0;
    logic [15:0] rd_val;
    logic [3:0]  rd_s;

    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; shift = 1'b0;
    start_s = 1'b0; cont_s = 1'b0; shift_s = 1'b0;

    // reset state
    steps(3);
    check("rst_ro_en", 32'(ro_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_sdo", 32'(sdo), 32'd0);
    rst_n = 1'b1;
    steps(2);
    check("idle_busy", 32'(busy), 32'd0);

    // single shot, period-8 oscillator: 8 edges in a 64-cycle window
    ro_half = 4;
    steps(20);
    fire_start(1'b0, 1, {1'b0, 16'd8}, 0, t0);
    check("start_busy", 32'(busy), 32'd1);
    check("start_ro_en", 32'(ro_en), 32'd1);
    wait_drain(200);
    step();
    check("after_done_busy", 32'(busy), 32'd0);
    check("after_done_ro_en", 32'(ro_en), 32'd0);
    check("done_pulse_width", 32'(done), 32'd0);

    // burst of 10 pulses inside the window, then serial readout of 0x000A
    ro_half = 0;
    steps(10);
    fire_start(1'b0, 1, {1'b0, 16'd10}, 0, t0);
    steps(6 + SETTLE_ADD);
    burst_req += 10;
    wait_drain(200);
    rd_val = 16'h000A;
    for (int i = 0; i <= 16; i++) begin
      check($sformatf("sdo_bit%0d", i), 32'(sdo), (i < 16) ? 32'(rd_val[15-i]) : 32'd0);
      shift = 1'b1;
      step();
    end
    shift = 1'b0;

    // continuous: three windows, stray starts while busy, continuous dropped in window 3
    ro_half = 4;
    steps(20);
    continuous = 1'b1;
    fire_start(1'b0, 3, {1'b0, 16'd8}, PERIOD, t0);
    while (cyc < t0 + 20) step();
    start = 1'b1; step(); start = 1'b0;
    while (cyc < t0 + LAT + 40) step();
    start = 1'b1; step(); start = 1'b0;
    while (cyc < t0 + LAT + PERIOD + 30) step();
    continuous = 1'b0;
    wait_drain(400);
    step();
    check("cont_end_busy", 32'(busy), 32'd0);
    check("cont_end_ro_en", 32'(ro_en), 32'd0);
    steps(80);
    check("cont_stays_idle", 32'(busy), 32'd0);

    // reset in the middle of the count window
    fire_start(1'b0, 0, 17'd0, 0, t0);
    steps(30);
    check("mid_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ro_en", 32'(ro_en), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_sdo", 32'(sdo), 32'd0);
    steps(3);
    rst_n = 1'b1;
    steps(5);
    fire_start(1'b0, 1, {1'b0, 16'd8}, 0, t0);
    wait_drain(200);

    // saturation on the 4-bit instance: 64 edges in 256 cycles, then a quiet window
    ro_half = 2;
    steps(20);
    fire_start(1'b1, 1, {1'b1, 16'h000F}, 0, t0);
    wait_drain(400);
    ro_half = 0;
    steps(10);
    fire_start(1'b1, 1, {1'b0, 16'h0000}, 0, t0);
    wait_drain(400);

    // shift held high across capture: the load wins, MSB of 4'hA appears first
    shift_s = 1'b1;
    fire_start(1'b1, 1, {1'b0, 16'h000A}, 0, t0);
    steps(8 + SETTLE_ADD);
    burst_req += 10;
    wait_drain(400);
    rd_s = 4'hA;
    for (int i = 0; i <= 4; i++) begin
      check($sformatf("sdo_s_bit%0d", i), 32'(sdo_s), (i < 4) ? 32'(rd_s[3-i]) : 32'd0);
      step();
    end
    shift_s = 1'b0;

    steps(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
